mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port stall  input  `StallBus  pipeline stall vector; bit 3 holds this stage, bit 4 holds the downstream stage.
REQ-004 SHALL have port ex_to_mem_bus  input  76  {pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}.
REQ-005 SHALL have port ex_to_mem1  input  66  {hi_we[65], lo_we[64], hi[63:32], lo[31:0]}.
REQ-006 SHALL have port data_sram_rdata  input  32  load data from the data SRAM.
REQ-007 SHALL have port data_sram_data_ok  input  1  one-cycle pulse; rdata valid this cycle.
REQ-008 SHALL have port mem_to_wb_bus  output  70  {pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}.
REQ-009 SHALL have port mem_to_id_bus  output  38  {rf_we, rf_waddr, rf_wdata}, the forwarding copy.
REQ-010 SHALL have port mem_to_wb_hilo  output  66  registered ex_to_mem1 passed through.
REQ-011 SHALL have port mem_to_id_hilo  output  66  same value as mem_to_wb_hilo, for forwarding.
REQ-012 SHALL have port stallreq_for_mem  output  1  request to stall the pipeline while load data is outstanding.

Function
REQ-013 SHALL hold both input buses in one stage register, R, updated every edge per REQ-014..016.
REQ-014 SHALL load R with 0 (bubble) when stall[3]=Stop and stall[4]=NoStop.
REQ-015 SHALL load R from the inputs when stall[3]=NoStop.
REQ-016 SHALL hold R unchanged when stall[3]=Stop and stall[4]=Stop.
REQ-017 SHALL classify R as a load when data_ram_en=1 and data_ram_wen=4'b0000; stores and non-memory ops SHALL never wait.
REQ-018 SHALL implement an FSM with states IDLE, WAIT, HAVE.
- IDLE: load in R and data_ok=0 -> WAIT.
- IDLE or WAIT: data_ok=1 and R is a load -> capture rdata into buf, go to HAVE.
- HAVE: R reloaded or bubbled (REQ-014/015) -> IDLE; otherwise stay in HAVE.
REQ-019 SHALL define load_data as buf in HAVE, otherwise data_sram_rdata.
REQ-020 SHALL drive stallreq_for_mem = load in R AND state!=HAVE AND data_ok=0, combinationally.
- There is no latency floor: a data_ok arriving in the first cycle the load sits in R causes no stall.
REQ-021 SHALL set rf_wdata = sel_rf_res ? load_data : ex_result.
REQ-022 SHALL force rf_we in both output buses to 0 while stallreq_for_mem=1, so a stale forward cannot occur.
REQ-023 SHALL ignore data_ok when R is not a load, and when in HAVE; buf SHALL not be overwritten in those cases.
REQ-024 SHALL let mem_to_wb_hilo and mem_to_id_hilo follow R unconditionally (no dependence on the FSM).
REQ-025 SHALL treat data_ok and a reload of R in the same cycle as completing the old load: the outputs use live rdata, and the FSM goes to IDLE.

Reset
REQ-026 SHALL, on a clock edge with resetn=0, clear R and buf to 0 and set the FSM to IDLE, overriding any stall or data_ok.
REQ-027 SHALL, as a result of REQ-026, drive every output to 0 after reset, including stallreq_for_mem.
REQ-028 SHALL discard any load in flight when reset is applied mid-WAIT; a data_ok arriving after reset SHALL be ignored.

Verification
REQ-029 ALU op: ex_result=0x1234, rf_we=1, waddr=5, stall=0 -> next cycle mem_to_wb_bus.rf_wdata=0x1234, waddr=5, stallreq=0.
REQ-030 Load, 3-cycle wait: load enters R, data_ok pulses on cycle 3 with rdata=0xDEADBEEF.
- Cycles 1-2: stallreq=1 and forwarded rf_we=0.
- Cycle 3: rf_wdata=0xDEADBEEF and stallreq=0.
REQ-031 Load while downstream is stalled: data_ok arrives with stall[3]=stall[4]=Stop, then rdata changes to 0x0 while the stall holds for 2 cycles.
- Output SHALL stay at the captured value (HAVE), and stallreq SHALL stay 0.
REQ-032 Bubble insertion: stall[3]=Stop, stall[4]=NoStop -> next cycle both buses are all-zero.
REQ-033 Reset during WAIT: resetn=0 for 1 cycle, then data_ok=1 with R empty.
- FSM SHALL be in IDLE, all outputs 0, and buf unchanged at 0.
REQ-034 hi/lo pass-through: ex_to_mem1={1,1,0xA,0xB} with stall=0 -> next cycle both hilo outputs equal that value.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: registers the EX-stage buses, waits out data-SRAM load latency
// and builds the write-back and forwarding buses.
module mem_stage #(
  parameter int STALL_W = 6
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [STALL_W-1:0] stall,
  input  logic [75:0]        ex_to_mem_bus,
  input  logic [65:0]        ex_to_mem1,
  input  logic [31:0]        data_sram_rdata,
  input  logic               data_sram_data_ok,
  output logic [69:0]        mem_to_wb_bus,
  output logic [37:0]        mem_to_id_bus,
  output logic [65:0]        mem_to_wb_hilo,
  output logic [65:0]        mem_to_id_hilo,
  output logic               stallreq_for_mem
);

  typedef struct packed {
    logic [31:0] pc;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_bus_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HAVE} state_t;

  ex_bus_t     r_bus;
  logic [65:0] r_hilo;
  logic [31:0] buf_q;
  state_t      state, state_nx;

  logic        reload, is_load, capture;
  logic [31:0] load_data, rf_wdata;
  logic        rf_we_out;

  // Only this stage's and the downstream stall bits matter here.
  logic unused_stall;
  assign unused_stall = ^{stall[STALL_W-1:5], stall[2:0]};

  // R changes (new op or bubble) unless both this and the next stage stop.
  assign reload  = !(stall[3] && stall[4]);
  assign is_load = r_bus.ram_en && (r_bus.ram_wen == 4'b0000);
  assign capture = is_load && data_sram_data_ok && (state != S_HAVE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_bus  <= '0;
      r_hilo <= '0;
    end else if (!stall[3]) begin
      r_bus  <= ex_bus_t'(ex_to_mem_bus);
      r_hilo <= ex_to_mem1;
    end else if (!stall[4]) begin
      r_bus  <= '0;
      r_hilo <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      buf_q <= '0;
      state <= S_IDLE;
    end else begin
      if (capture && !reload) buf_q <= data_sram_rdata;
      state <= state_nx;
    end
  end

  // A reload always ends the current op; a same-cycle data_ok completes it
  // with live rdata, so there is nothing to keep.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_WAIT: begin
        if (reload)               state_nx = S_IDLE;
        else if (capture)         state_nx = S_HAVE;
        else if (is_load)         state_nx = S_WAIT;
      end
      S_HAVE: if (reload)         state_nx = S_IDLE;
      default:                    state_nx = S_IDLE;
    endcase
  end

  assign stallreq_for_mem = is_load && (state != S_HAVE) && !data_sram_data_ok;
  assign load_data        = (state == S_HAVE) ? buf_q : data_sram_rdata;
  assign rf_wdata         = r_bus.sel_rf_res ? load_data : r_bus.ex_result;
  // Suppress the write while load data is missing so ID never forwards junk.
  assign rf_we_out        = r_bus.rf_we && !stallreq_for_mem;

  assign mem_to_wb_bus  = {r_bus.pc, rf_we_out, r_bus.rf_waddr, rf_wdata};
  assign mem_to_id_bus  = {rf_we_out, r_bus.rf_waddr, rf_wdata};
  assign mem_to_wb_hilo = r_hilo;
  assign mem_to_id_hilo = r_hilo;

endmodule

// File: tb/tb_mem_stage.sv
// Scenario bench for mem_stage: expected output snapshots are queued as
// stimulus is applied and popped when the DUT outputs are sampled.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        resetn;
  logic [5:0]  stall;
  logic [75:0] ex_bus;
  logic [65:0] ex1;
  logic [31:0] rdata;
  logic        dok;
  logic [69:0] wb_bus;
  logic [37:0] id_bus;
  logic [65:0] wb_hilo, id_hilo;
  logic        stallreq;

  localparam logic [5:0] HOLD = 6'h1f;

  int total = 0;
  int bad   = 0;
  logic [240:0] sb[$];
  logic [240:0] obs, e;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .resetn(resetn), .stall(stall),
    .ex_to_mem_bus(ex_bus), .ex_to_mem1(ex1),
    .data_sram_rdata(rdata), .data_sram_data_ok(dok),
    .mem_to_wb_bus(wb_bus), .mem_to_id_bus(id_bus),
    .mem_to_wb_hilo(wb_hilo), .mem_to_id_hilo(id_hilo),
    .stallreq_for_mem(stallreq)
  );

  assign obs = {wb_bus, id_bus, wb_hilo, id_hilo, stallreq};

  function automatic logic [75:0] mk(logic [31:0] pc, logic en, logic [3:0] wen,
                                     logic sel, logic we, logic [4:0] wa, logic [31:0] res);
    return {pc, en, wen, sel, we, wa, res};
  endfunction

  function automatic logic [240:0] ex(logic [31:0] pc, logic we, logic [4:0] wa,
                                      logic [31:0] wd, logic [65:0] hl, logic sr);
    return {pc, we, wa, wd, we, wa, wd, hl, hl, sr};
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic test_reset;
    resetn = 1'b0; stall = 6'h3f; dok = 1'b1; rdata = 32'hffff_ffff;
    ex_bus = mk(32'h44, 1'b1, 4'h0, 1'b1, 1'b1, 5'd3, 32'h77); ex1 = '1;
    sb.push_back(ex(0, 0, 0, 0, 0, 0));
    tick; settle;
    e = sb.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL reset: got %h want %h", obs, e); end
    tick;
  endtask

  task automatic test_alu;
    resetn = 1'b1; stall = '0; dok = 1'b0; ex1 = '0;
    ex_bus = mk(32'h100, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 32'h1234);
    sb.push_back(ex(32'h100, 1, 5, 32'h1234, 0, 0));
    tick; settle;
    e = sb.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL alu: got %h want %h", obs, e); end
  endtask

  task automatic test_load_wait;
    ex_bus = mk(32'h200, 1'b1, 4'h0, 1'b1, 1'b1, 5'd7, 32'h55); stall = '0; dok = 1'b0;
    tick;
    for (int c = 1; c <= 2; c++) begin
      stall = HOLD; dok = 1'b0; rdata = 32'h1111_1111;
      sb.push_back(ex(32'h200, 0, 7, 32'h1111_1111, 0, 1));
      settle;
      e = sb.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL load_wait c%0d: got %h want %h", c, obs, e); end
      tick;
    end
    stall = '0; dok = 1'b1; rdata = 32'hDEAD_BEEF;
    ex_bus = mk(32'h204, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 32'h99);
    sb.push_back(ex(32'h200, 1, 7, 32'hDEAD_BEEF, 0, 0));
    settle;
    e = sb.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL load_done: got %h want %h", obs, e); end
    tick;
    dok = 1'b0; rdata = 32'h5;
    sb.push_back(ex(32'h204, 1, 3, 32'h99, 0, 0));
    settle;
    e = sb.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL load_reload: got %h want %h", obs, e); end
    tick;
  endtask

  task automatic test_downstream_stall;
    logic [5:0]  st[4] = '{HOLD, HOLD, HOLD, 6'h08};
    logic        dk[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] rd[4] = '{32'hCAFE_F00D, 32'h0, 32'h99, 32'h0};
    ex_bus = mk(32'h300, 1'b1, 4'h0, 1'b1, 1'b1, 5'd9, 32'h0); stall = '0; dok = 1'b0;
    tick;
    for (int c = 0; c < 4; c++) begin
      stall = st[c]; dok = dk[c]; rdata = rd[c];
      sb.push_back(ex(32'h300, 1, 9, 32'hCAFE_F00D, 0, 0));
      settle;
      e = sb.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL have c%0d: got %h want %h", c, obs, e); end
      tick;
    end
    stall = '0; ex_bus = '0; dok = 1'b0;
    sb.push_back(ex(0, 0, 0, 0, 0, 0));
    settle;
    e = sb.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL bubble: got %h want %h", obs, e); end
    tick;
  endtask

  task automatic test_reset_wait;
    ex_bus = mk(32'h400, 1'b1, 4'h0, 1'b1, 1'b1, 5'd4, 32'h0); stall = '0; dok = 1'b0;
    tick;
    stall = HOLD; rdata = 32'h3;
    sb.push_back(ex(32'h400, 0, 4, 32'h3, 0, 1));
    settle;
    e = sb.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL rw_wait: got %h want %h", obs, e); end
    tick;
    resetn = 1'b0;
    tick;
    resetn = 1'b1; dok = 1'b1; rdata = 32'h77;
    sb.push_back(ex(0, 0, 0, 0, 0, 0));
    settle;
    e = sb.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL rw_after_reset: got %h want %h", obs, e); end
    tick;
    stall = '0; dok = 1'b0;
    tick;
    stall = HOLD; rdata = 32'h1;
    sb.push_back(ex(32'h400, 0, 4, 32'h1, 0, 1));
    settle;
    e = sb.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL rw_idle: got %h want %h", obs, e); end
    tick;
  endtask

  task automatic test_hilo_store;
    logic [65:0] hv = {1'b1, 1'b1, 32'hA, 32'hB};
    stall = '0; dok = 1'b0; rdata = 32'h6; ex1 = hv;
    ex_bus = mk(32'h500, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h8);
    sb.push_back(ex(32'h500, 0, 0, 32'h8, hv, 0));
    tick; settle;
    e = sb.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL hilo_store: got %h want %h", obs, e); end
    ex1 = '0; ex_bus = mk(32'h504, 1'b0, 4'h0, 1'b0, 1'b1, 5'd31, 32'hFFFF_0000);
    sb.push_back(ex(32'h504, 1, 31, 32'hFFFF_0000, 0, 0));
    tick; settle;
    e = sb.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL hilo_clear: got %h want %h", obs, e); end
  endtask

  initial begin
    resetn = 1'b0; stall = '0; ex_bus = '0; ex1 = '0; rdata = '0; dok = 1'b0;
    #1;
    test_reset;
    test_alu;
    test_load_wait;
    test_downstream_stall;
    test_reset_wait;
    test_hilo_store;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
